// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter with frame strobes and a one-word holding buffer.
// Optional even-parity trailer bit when PISO_SERIAL_TX_PARITY_EN is defined.
module piso_serial_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             msb_first_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             sout_o,
  output logic             sframe_o,
  output logic             slast_o,
  output logic             sbusy_o
);

`ifdef PISO_SERIAL_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // state | meaning: IDLE = no frame on sout; SHIFT = one frame bit per cycle
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             ord_q, ord_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_ord_q, hold_ord_d;
  logic             hold_full_q, hold_full_d;
  logic             sout_q, sout_d;
  logic             sframe_q, sframe_d;
  logic             slast_q, slast_d;
  logic             sbusy_q, sbusy_d;
`ifdef PISO_SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;
  logic             load_ord;
  logic             bit_d;

  assign din_ready_o = !hold_full_q && !reset_i;
  assign accept      = din_valid_i && din_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ord_d       = ord_q;
    hold_d      = hold_q;
    hold_ord_d  = hold_ord_q;
    hold_full_d = hold_full_q;
`ifdef PISO_SERIAL_TX_PARITY_EN
    par_d       = par_q;
`endif
    load_en     = 1'b0;
    load_word   = din_i;
    load_ord    = msb_first_i;

    if (state_q == IDLE) begin
      if (accept) begin
        load_en = 1'b1;
        state_d = SHIFT;
      end
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
      sh_d  = ord_q ? (sh_q << 1) : (sh_q >> 1);
      if (accept) begin
        hold_d      = din_i;
        hold_ord_d  = msb_first_i;
        hold_full_d = 1'b1;
      end
    end else if (hold_full_q) begin
      load_en     = 1'b1;
      load_word   = hold_q;
      load_ord    = hold_ord_q;
      hold_full_d = 1'b0;
    end else if (accept) begin
      load_en = 1'b1;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (load_en) begin
      sh_d  = load_word;
      ord_d = load_ord;
      cnt_d = '0;
`ifdef PISO_SERIAL_TX_PARITY_EN
      par_d = ^load_word;
`endif
    end

    // Outputs are computed from next state so they can be registered.
`ifdef PISO_SERIAL_TX_PARITY_EN
    bit_d = (cnt_d == CW'(WIDTH)) ? par_d : (ord_d ? sh_d[WIDTH-1] : sh_d[0]);
`else
    bit_d = ord_d ? sh_d[WIDTH-1] : sh_d[0];
`endif
    sbusy_d  = (state_d == SHIFT);
    sout_d   = sbusy_d && bit_d;
    sframe_d = sbusy_d && (cnt_d == '0);
    slast_d  = sbusy_d && (cnt_d == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      ord_q       <= 1'b0;
      hold_q      <= '0;
      hold_ord_q  <= 1'b0;
      hold_full_q <= 1'b0;
      sout_q      <= 1'b0;
      sframe_q    <= 1'b0;
      slast_q     <= 1'b0;
      sbusy_q     <= 1'b0;
`ifdef PISO_SERIAL_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ord_q       <= ord_d;
      hold_q      <= hold_d;
      hold_ord_q  <= hold_ord_d;
      hold_full_q <= hold_full_d;
      sout_q      <= sout_d;
      sframe_q    <= sframe_d;
      slast_q     <= slast_d;
      sbusy_q     <= sbusy_d;
`ifdef PISO_SERIAL_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign sout_o   = sout_q;
  assign sframe_o = sframe_q;
  assign slast_o  = slast_q;
  assign sbusy_o  = sbusy_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: expected frame bits are queued on acceptance and
// compared every negedge; an empty queue means the line must be idle.
module tb_piso_serial_tx;
  localparam int WIDTH = 4;
`ifdef PISO_SERIAL_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [WIDTH-1:0] din_i = '0;
  logic             msb_first_i = 1'b0;
  logic             din_valid_i = 1'b0;
  logic             din_ready_o;
  logic             sout_o;
  logic             sframe_o;
  logic             slast_o;
  logic             sbusy_o;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_m;
  int   checks = 0;
  int   errors = 0;

  piso_serial_tx #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .din_i       (din_i),
    .msb_first_i (msb_first_i),
    .din_valid_i (din_valid_i),
    .din_ready_o (din_ready_o),
    .sout_o      (sout_o),
    .sframe_o    (sframe_o),
    .slast_o     (slast_o),
    .sbusy_o     (sbusy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w, input logic m);
    exp_t e;
    for (int i = 0; i < WIDTH; i++) begin
      e.b = m ? w[WIDTH-1-i] : w[i];
      e.f = (i == 0);
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
`ifdef PISO_SERIAL_TX_PARITY_EN
    e.b = ^w;
    e.f = 1'b0;
    e.l = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] w, input logic m);
    logic got;
    got = 1'b0;
    din_valid_i = 1'b1;
    din_i = w;
    msb_first_i = m;
    for (int t = 0; t < 40 && !got; t++) begin
      got = din_ready_o;
      @(posedge clk_i);
      #1;
    end
    chk("send_accept", got, 1'b1);
    if (got) push_frame(w, m);
    din_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk_i);
    chk("drain_done", exp_q.size() == 0, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() == 0) begin
      chk("idle_sbusy", sbusy_o, 1'b0);
      chk("idle_sout", sout_o, 1'b0);
      chk("idle_sframe", sframe_o, 1'b0);
      chk("idle_slast", slast_o, 1'b0);
    end else begin
      exp_m = exp_q.pop_front();
      chk("bit_sbusy", sbusy_o, 1'b1);
      chk("bit_sout", sout_o, exp_m.b);
      chk("bit_sframe", sframe_o, exp_m.f);
      chk("bit_slast", slast_o, exp_m.l);
    end
  end

  initial begin
    // Reset for two edges
    @(posedge clk_i); #1;
    chk("rdy_in_reset", din_ready_o, 1'b0);
    @(posedge clk_i); #1;
    chk("rdy_in_reset", din_ready_o, 1'b0);
    reset_i = 1'b0;
    #1;
    chk("rdy_after_release", din_ready_o, 1'b1);

    // Single words, both orders
    send(4'b1011, 1'b0);
    wait_idle();
    send(4'b1011, 1'b1);
    wait_idle();
    send(4'b0011, 1'b0);
    wait_idle();

    // Streaming with valid held high
    send(4'hA, 1'b0);
    chk("rdy_hold_empty", din_ready_o, 1'b1);
    send(4'h5, 1'b1);
    chk("rdy_hold_full", din_ready_o, 1'b0);
    send(4'h3, 1'b0);
    chk("rdy_hold_full2", din_ready_o, 1'b0);
    wait_idle();

    // Reset during the second bit with a word held
    send(4'hC, 1'b0);
    send(4'h6, 1'b1);
    reset_i = 1'b1;
    #1;
    chk("rdy_mid_reset", din_ready_o, 1'b0);
    @(posedge clk_i); #1;
    exp_q.delete();
    reset_i = 1'b0;
    #1;
    chk("rdy_after_abort", din_ready_o, 1'b1);
    repeat (8) @(posedge clk_i);
    #1;
    send(4'hF, 1'b0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
